// File: rtl/bit_serializer.sv
// bit_serializer
//   Captures a WIDTH-bit parallel word and shifts it out one bit per clock on
//   a registered serial output. A new word can be accepted during the final
//   bit of the current one, so consecutive frames leave no gap on dout.
//
// Parameters
//   WIDTH       frame length in bits (2..32)
//   MSB_FIRST   1: data_in[WIDTH-1] goes out first, 0: data_in[0] goes out first
//   IDLE_LEVEL  level driven on dout while no frame bit is present
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high
//   load        capture request, honoured only while ready=1
//   data_in     parallel frame
//   ready       a load is accepted on this cycle
//   dout        serial bit stream (registered)
//   dout_valid  dout carries a frame bit
//   last        dout carries the final bit of the frame
//   frame_cnt   completed-frame count, wraps modulo 256
//
// States
//   state | meaning
//   IDLE  | no frame in flight, dout at IDLE_LEVEL, ready for load
//   SHIFT | one frame bit per cycle on dout, ready only on the last bit
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic [7:0]       frame_cnt
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             dout_r;
  logic             at_last;
  logic             capture;
  logic             advance;
  logic [WIDTH-1:0] src;
  logic             head;
  logic [WIDTH-1:0] tail;

  assign at_last = (state == SHIFT) && (bit_cnt == LAST_CNT);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ready is also gated by reset so a load presented during reset is never
  // accepted; load and data_in never reach an output combinationally.
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    dout_valid = 1'b0;
    last       = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        ready   = !reset;
        capture = load && !reset;
        if (capture) state_nxt = SHIFT;
      end
      SHIFT: begin
        dout_valid = 1'b1;
        if (at_last) begin
          last    = 1'b1;
          ready   = !reset;
          capture = load && !reset;
          if (!capture) state_nxt = IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The register holds the bits not yet on dout: on capture the first bit
  // goes straight to dout_r and the remainder is stored pre-shifted.
  always_comb begin
    src = capture ? data_in : shreg;
    if (MSB_FIRST != 0) begin
      head = src[WIDTH-1];
      tail = {src[WIDTH-2:0], 1'b0};
    end else begin
      head = src[0];
      tail = {1'b0, src[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      dout_r    <= IDLE_LEVEL;
      frame_cnt <= '0;
    end else begin
      if (capture) begin
        bit_cnt <= '0;
        dout_r  <= head;
        shreg   <= tail;
      end else if (advance) begin
        bit_cnt <= bit_cnt + CW'(1);
        dout_r  <= head;
        shreg   <= tail;
      end else if (state == SHIFT) begin
        bit_cnt <= '0;
        dout_r  <= IDLE_LEVEL;
      end
      if (at_last) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign dout = dout_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance
// (WIDTH=4, IDLE_LEVEL=0) driven by the same stimulus.
module tb_bit_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] data_in;

  logic       m_ready, m_dout, m_valid, m_last;
  logic [7:0] m_fc;
  logic       l_ready, l_dout, l_valid, l_last;
  logic [7:0] l_fc;

  int n_eval = 0;
  int n_fail = 0;
  logic [7:0] exp_fc = 8'd0;

  always #5 clock = ~clock;

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clock(clock), .reset(reset), .load(load), .data_in(data_in),
    .ready(m_ready), .dout(m_dout), .dout_valid(m_valid), .last(m_last),
    .frame_cnt(m_fc)
  );

  bit_serializer #(.WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .load(load), .data_in(data_in),
    .ready(l_ready), .dout(l_dout), .dout_valid(l_valid), .last(l_last),
    .frame_cnt(l_fc)
  );

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic rdy, input logic [7:0] fc);
    chk({tag, " m_valid"}, {7'd0, m_valid}, 8'd0);
    chk({tag, " l_valid"}, {7'd0, l_valid}, 8'd0);
    chk({tag, " m_dout"},  {7'd0, m_dout},  8'd0);
    chk({tag, " l_dout"},  {7'd0, l_dout},  8'd0);
    chk({tag, " m_last"},  {7'd0, m_last},  8'd0);
    chk({tag, " m_ready"}, {7'd0, m_ready}, {7'd0, rdy});
    chk({tag, " l_ready"}, {7'd0, l_ready}, {7'd0, rdy});
    chk({tag, " m_fc"},    m_fc, fc);
    chk({tag, " l_fc"},    l_fc, fc);
  endtask

  // Caller has already set load=1 and data_in; em/el list the expected dout
  // sequence with the first bit in [3].
  task automatic run_frame(input string tag, input logic [3:0] em, input logic [3:0] el,
                           input logic ld_last, input logic [3:0] nd, input logic junk,
                           input logic [7:0] fc);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk({tag, " m_dout"},  {7'd0, m_dout},  {7'd0, em[3-i]});
      chk({tag, " l_dout"},  {7'd0, l_dout},  {7'd0, el[3-i]});
      chk({tag, " m_valid"}, {7'd0, m_valid}, 8'd1);
      chk({tag, " l_valid"}, {7'd0, l_valid}, 8'd1);
      chk({tag, " m_last"},  {7'd0, m_last},  (i == 3) ? 8'd1 : 8'd0);
      chk({tag, " l_last"},  {7'd0, l_last},  (i == 3) ? 8'd1 : 8'd0);
      chk({tag, " m_ready"}, {7'd0, m_ready}, (i == 3) ? 8'd1 : 8'd0);
      chk({tag, " m_fc"},    m_fc, fc);
      chk({tag, " l_fc"},    l_fc, fc);
      if (i == 3) begin
        load    = ld_last;
        data_in = nd;
      end else if (junk && (i == 1 || i == 2)) begin
        load    = 1'b1;
        data_in = 4'b1111;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b1;
    data_in = 4'b1010;

    // load held during reset is ignored, ready low throughout
    cyc();
    chk_idle("rst1", 1'b0, 8'd0);
    cyc();
    chk_idle("rst2", 1'b0, 8'd0);

    reset = 1'b0;
    load  = 1'b0;
    cyc();
    chk_idle("post_rst", 1'b1, 8'd0);

    // single frame 1011: MSB 1,0,1,1 / LSB 1,1,0,1
    data_in = 4'b1011;
    load    = 1'b1;
    run_frame("f1011", 4'b1011, 4'b1101, 1'b0, 4'b0000, 1'b0, exp_fc);
    exp_fc = exp_fc + 8'd1;
    cyc();
    chk_idle("f1011_end", 1'b1, exp_fc);

    // back-to-back 1100 then 0011
    data_in = 4'b1100;
    load    = 1'b1;
    run_frame("b2b_a", 4'b1100, 4'b0011, 1'b1, 4'b0011, 1'b0, exp_fc);
    exp_fc = exp_fc + 8'd1;
    run_frame("b2b_b", 4'b0011, 4'b1100, 1'b0, 4'b0000, 1'b0, exp_fc);
    exp_fc = exp_fc + 8'd1;
    cyc();
    chk_idle("b2b_end", 1'b1, exp_fc);

    // frame 1010 with a stray load of 1111 while busy
    data_in = 4'b1010;
    load    = 1'b1;
    run_frame("busy_ld", 4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b1, exp_fc);
    exp_fc = exp_fc + 8'd1;
    cyc();
    chk_idle("busy_end", 1'b1, exp_fc);
    cyc();
    chk_idle("busy_end2", 1'b1, exp_fc);

    // reset during the second bit aborts the frame
    data_in = 4'b1010;
    load    = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    chk("abort bit2 m_dout", {7'd0, m_dout}, 8'd0);
    chk("abort bit2 l_dout", {7'd0, l_dout}, 8'd1);
    reset = 1'b1;
    cyc();
    chk_idle("abort_rst", 1'b0, 8'd0);
    reset = 1'b0;
    cyc();
    chk_idle("abort_post", 1'b1, 8'd0);

    // 256 contiguous frames: frame_cnt 255 then wraps to 0
    data_in = 4'b1001;
    load    = 1'b1;
    cyc();
    for (int f = 1; f <= 256; f++) begin
      for (int c = 0; c < 4; c++) begin
        cyc();
        chk("wrap m_valid", {7'd0, m_valid}, 8'd1);
        chk("wrap m_last", {7'd0, m_last}, (c == 2) ? 8'd1 : 8'd0);
      end
      if (f == 255) begin
        chk("wrap m_fc255", m_fc, 8'd255);
        chk("wrap l_fc255", l_fc, 8'd255);
      end
      if (f == 256) begin
        chk("wrap m_fc0", m_fc, 8'd0);
        chk("wrap l_fc0", l_fc, 8'd0);
      end
    end
    load = 1'b0;
    cyc();
    cyc();
    cyc();
    cyc();
    chk_idle("wrap_end", 1'b1, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: frame length in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = send data_in[WIDTH-1] first; 0 = send data_in[0] first.
REQ-003 Parameter IDLE_LEVEL, default 1'b0: dout level whenever dout_valid is 0.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 load  input  1  request to capture data_in; sampled only when ready=1.
REQ-007 data_in  input  WIDTH  parallel frame to serialize.
REQ-008 ready  output  1  block accepts load on this cycle.
REQ-009 dout  output  1  serial bit stream, registered; drives the downstream sequence detector's din.
REQ-010 dout_valid  output  1  dout carries a frame bit this cycle.
REQ-011 last  output  1  dout carries the final bit of the current frame.
REQ-012 frame_cnt  output  8  count of completed frames, wraps modulo 256.

Function
REQ-013 The block SHALL implement two states: IDLE and SHIFT.
REQ-014 IDLE: ready=1, dout_valid=0, last=0, dout=IDLE_LEVEL.
REQ-015 IDLE->SHIFT on a rising edge with load=1 and ready=1; data_in is captured into an internal WIDTH-bit shift register on that edge.
REQ-016 Latency: first frame bit SHALL appear on dout in the cycle immediately after the capturing edge (1 cycle).
REQ-017 SHIFT: dout_valid=1 for exactly WIDTH consecutive cycles, one bit per cycle, in the order set by MSB_FIRST.
REQ-018 Bit counter SHALL be ceil(log2(WIDTH)) bits wide, cleared on capture, incremented once per SHIFT cycle; last=1 when counter = WIDTH-1.
REQ-019 ready SHALL be 1 during the last SHIFT cycle (back-to-back support); otherwise 0 in SHIFT.
REQ-020 On the edge ending the last bit: load=1 -> capture new data_in, remain in SHIFT, counter cleared, next frame's first bit follows with no gap; load=0 -> go to IDLE.
REQ-021 frame_cnt SHALL increment by 1 on the edge ending each last-bit cycle; 255 wraps to 0.
REQ-022 load while ready=0 SHALL be ignored with no side effects; data_in changes during SHIFT SHALL not affect the frame in flight.
REQ-023 ready, dout_valid and last are decoded from registered state only; no combinational path from load or data_in to any output.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, clear shift register, bit counter and frame_cnt to 0, and set dout=IDLE_LEVEL.
REQ-025 ready SHALL be 0 in every cycle where reset=1; load presented with reset=1 SHALL be ignored.
REQ-026 reset during SHIFT SHALL abort the frame: no further bits, no frame_cnt increment, outputs at IDLE values from the next cycle.
REQ-027 First cycle after reset deasserts: ready=1, dout_valid=0, frame_cnt=0.

Verification (WIDTH=4, IDLE_LEVEL=0 unless stated)
REQ-028 MSB_FIRST=1, load data_in=4'b1011 in IDLE -> next 4 cycles dout=1,0,1,1, dout_valid=1, last=1 only on 4th, then IDLE; frame_cnt 0->1.
REQ-029 MSB_FIRST=0, data_in=4'b1011 -> dout=1,1,0,1; frame_cnt increments once.
REQ-030 Back-to-back: load 4'b1100 then load 4'b0011 held during its last bit -> 8 contiguous valid cycles dout=1,1,0,0,0,0,1,1; frame_cnt +2.
REQ-031 load 4'b1111 asserted during bits 2-3 of frame 4'b1010 -> frame 1,0,1,0 unaffected, second load ignored, block returns to IDLE.
REQ-032 reset asserted during bit 2 of a frame -> next cycle dout_valid=0, dout=0, ready=1 after deassertion, frame_cnt=0.
REQ-033 256 complete frames after reset -> frame_cnt reads 255 after frame 255, 0 after frame 256.
